disparity_search_scheduler: RTL and testbench
=============================================

Name: disparity_search_scheduler

Overview:
- Sequences one shared, fully pipelined hamming_distance instance across all disparity candidates of a pixel.
- Accepts one left census word plus a packed window of MAX_DISP right census words via valid/ready.
- Issues one candidate per cycle into the Hamming pipeline and collects the returned costs.
- Performs winner-take-all minimum selection and outputs best disparity and cost. Sits between the census transform stage and the disparity map writer.

Parameters:
- CENSUS_WIDTH, 8, census word width; 8 or 24, matching the attached hamming_distance.
- MAX_DISP, 16, number of disparity candidates per pixel; must be >= 2.
- UNIQ_MARGIN, 1, minimum (second_best - best) cost gap for res_unique; used only with the optional feature.
- Derived localparams: DIST_W = $clog2(CENSUS_WIDTH+1); DISP_W = $clog2(MAX_DISP).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  pixel request valid
- in_ready  out  1  scheduler can accept a pixel
- in_census_left  in  CENSUS_WIDTH  left census word
- in_census_right  in  MAX_DISP*CENSUS_WIDTH  candidate d occupies bits [d*CENSUS_WIDTH +: CENSUS_WIDTH]
- hd_census_left  out  CENSUS_WIDTH  to hamming_distance.census_left
- hd_census_right  out  CENSUS_WIDTH  to hamming_distance.census_right
- hd_valid  out  1  to hamming_distance.valid_in
- hd_dist  in  DIST_W  from hamming_distance.hamming_dist
- hd_dist_valid  in  1  from hamming_distance.valid_out
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_disp  out  DISP_W  winning disparity
- res_cost  out  DIST_W  winning cost
- res_unique  out  1  uniqueness flag
- stray_err  out  1  sticky: a cost returned while no search was in flight

Behaviour:
- Reset values: in_ready=0 while rst is high, then 1 from the first cycle after release. All other outputs are 0, state=IDLE, and all counters are 0.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch the left word and the right bus, clear issue_idx and ret_cnt, set best_cost to all-ones, and go to ISSUE.
- FSM state ISSUE:
  - in_ready=0. Registered outputs each cycle: hd_valid=1, hd_census_left=latched left, hd_census_right=right[issue_idx]; then issue_idx++.
  - Candidate d appears on the hd_* outputs in cycle T+1+d, where T is the accept cycle.
  - After candidate MAX_DISP-1 is issued, go to DRAIN with hd_valid=0 from the next cycle.
  - There is no stall: the Hamming pipeline always accepts.
- Returns: on hd_dist_valid while in ISSUE or DRAIN, the return is candidate ret_cnt. The pipeline preserves order.
  - If hd_dist < best_cost (strict), set best_cost=hd_dist and best_disp=ret_cnt.
  - Then ret_cnt++.
  - Ties keep the smaller disparity.
  - Returns may overlap ISSUE.
- FSM state DRAIN: wait until the return with ret_cnt==MAX_DISP-1 is consumed, then go to DONE.
- FSM state DONE:
  - res_valid=1; res_disp and res_cost hold stable.
  - On res_ready, go to IDLE with res_valid=0 next cycle.
  - Next-pixel accept is possible no earlier than the cycle after the handshake.
- Latency: res_valid rises in the cycle after the last return. With the 8-bit Hamming pipeline (4 cycles), that is T + MAX_DISP + 5.
- Stray returns: hd_dist_valid in IDLE or DONE is dropped and sets stray_err, which clears only on rst.
- Reset mid-operation: immediate return to IDLE with everything cleared. Results from the pipeline still in flight after reset count as stray and set stray_err. The integrator resets both blocks together to avoid this.
- Width rules: best_cost is DIST_W wide, initialised to all-ones. The maximum real cost, CENSUS_WIDTH, never exceeds all-ones, so the first return always updates.

Optional Feature:
- Macro DISP_UNIQUENESS_CHECK_EN.
- Defined:
  - Also track second_best, the smallest cost among non-winning candidates, initialised to all-ones.
  - Update rule: new < best gives second=best, best=new; else new < second gives second=new.
  - res_unique=1 iff (second_best - best_cost) >= UNIQ_MARGIN. Equal best costs therefore give res_unique=0 when UNIQ_MARGIN >= 1.
  - res_unique is valid with res_valid and is 0 at reset.
- Undefined: no second_best logic; res_unique is tied to 1.

Test Plan:
- All MAX_DISP=16 right words equal to left (8'hA5) -> res_disp=0, res_cost=0; res_valid at T+21; hd_valid high exactly 16 cycles, T+1..T+16.
- left=8'h00; right[d]=8'hFF except right[5]=8'h01 -> res_disp=5, res_cost=1.
- left=8'h00; right[3]=right[9]=8'h01, others 8'h0F -> res_disp=3, res_cost=1. With DISP_UNIQUENESS_CHECK_EN and UNIQ_MARGIN=1 -> res_unique=0; change right[9] to 8'h03 -> res_unique=1.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_disp and res_cost stable, in_ready=0, no hd_valid. Release -> IDLE next cycle, then back-to-back pixel accepted.
- Assert rst during ISSUE after 6 issues -> all outputs 0 and IDLE immediately. In-flight returns set stray_err=1, and the next pixel still yields a correct result.

Source files
------------

// File: rtl/disparity_search_scheduler.sv
// disparity_search_scheduler
// Time-shares one fully pipelined hamming_distance instance across all
// disparity candidates of a pixel, then does winner-take-all selection.
//
// Ports
//   clk, rst             rising-edge clock, async active-high reset
//   in_valid/in_ready    pixel request handshake
//   in_census_left       left census word
//   in_census_right      MAX_DISP packed right words, candidate d at [d*CW +: CW]
//   hd_census_left/right candidate operands to the Hamming pipeline
//   hd_valid             candidate strobe to the Hamming pipeline
//   hd_dist/hd_dist_valid cost returned by the Hamming pipeline (in order)
//   res_valid/res_ready  result handshake
//   res_disp, res_cost   winning disparity and its cost
//   res_unique           best cost beats the runner-up by at least UNIQ_MARGIN
//   stray_err            sticky; a cost arrived while no search was in flight
//
// Build option: define DISP_UNIQUENESS_CHECK_EN to track the second-best cost
// and drive res_unique from it; otherwise res_unique is tied to 1.
//
// state | meaning
// IDLE  | waiting for a pixel; in_ready high
// ISSUE | one candidate per cycle onto hd_*; costs may already be returning
// DRAIN | all candidates issued; waiting for the last cost
// DONE  | result held on res_*; waiting for res_ready

module disparity_search_scheduler #(
   parameter int CENSUS_WIDTH = 8,
   parameter int MAX_DISP     = 16,
   parameter int UNIQ_MARGIN  = 1,
   localparam int DIST_W = $clog2(CENSUS_WIDTH + 1),
   localparam int DISP_W = $clog2(MAX_DISP)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [CENSUS_WIDTH-1:0]          in_census_left,
   input  logic [MAX_DISP*CENSUS_WIDTH-1:0] in_census_right,
   output logic [CENSUS_WIDTH-1:0]          hd_census_left,
   output logic [CENSUS_WIDTH-1:0]          hd_census_right,
   output logic                             hd_valid,
   input  logic [DIST_W-1:0]                hd_dist,
   input  logic                             hd_dist_valid,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [DISP_W-1:0]                res_disp,
   output logic [DIST_W-1:0]                res_cost,
   output logic                             res_unique,
   output logic                             stray_err
);

   if (MAX_DISP < 2 || UNIQ_MARGIN < 0) begin : g_bad_param
      $error("disparity_search_scheduler: MAX_DISP must be >= 2 and UNIQ_MARGIN >= 0");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam logic [DISP_W-1:0] LAST = DISP_W'(MAX_DISP - 1);

   state_t                  state_q, state_d;
   logic [DISP_W-1:0]       issue_idx_q, issue_idx_d;
   logic [DISP_W-1:0]       ret_cnt_q, ret_cnt_d;
   logic [DIST_W-1:0]       best_cost_q, best_cost_d;
   logic [DISP_W-1:0]       best_disp_q, best_disp_d;
   logic [CENSUS_WIDTH-1:0] right_q [MAX_DISP];
   logic [CENSUS_WIDTH-1:0] right_d [MAX_DISP];
   logic                    hd_valid_q, hd_valid_d;
   logic [CENSUS_WIDTH-1:0] hd_left_q, hd_left_d;
   logic [CENSUS_WIDTH-1:0] hd_right_q, hd_right_d;
   logic                    stray_q, stray_d;
   logic                    ret_take;
`ifdef DISP_UNIQUENESS_CHECK_EN
   logic [DIST_W-1:0]       second_q, second_d;
   logic [DIST_W-1:0]       cost_gap;
`endif

   // Costs are only meaningful while a search is in flight; anything else is stray.
   assign ret_take = hd_dist_valid && (state_q == S_ISSUE || state_q == S_DRAIN);

   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      ret_cnt_d   = ret_cnt_q;
      best_cost_d = best_cost_q;
      best_disp_d = best_disp_q;
      right_d     = right_q;
      hd_valid_d  = 1'b0;
      hd_left_d   = hd_left_q;
      hd_right_d  = hd_right_q;
      stray_d     = stray_q;
`ifdef DISP_UNIQUENESS_CHECK_EN
      second_d    = second_q;
`endif

      if (ret_take) begin
         // strict compare: on a tie the earlier (smaller) disparity survives
         if (hd_dist < best_cost_q) begin
            best_cost_d = hd_dist;
            best_disp_d = ret_cnt_q;
`ifdef DISP_UNIQUENESS_CHECK_EN
            second_d    = best_cost_q;
         end else if (hd_dist < second_q) begin
            second_d    = hd_dist;
`endif
         end
         ret_cnt_d = ret_cnt_q + 1'b1;
      end

      if (hd_dist_valid && !ret_take) begin
         stray_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               for (int d = 0; d < MAX_DISP; d++) begin
                  right_d[d] = in_census_right[d*CENSUS_WIDTH +: CENSUS_WIDTH];
               end
               issue_idx_d = '0;
               ret_cnt_d   = '0;
               best_cost_d = '1;
               best_disp_d = '0;
`ifdef DISP_UNIQUENESS_CHECK_EN
               second_d    = '1;
`endif
               // candidate 0 goes out in the cycle right after the accept
               hd_valid_d  = 1'b1;
               hd_left_d   = in_census_left;
               hd_right_d  = in_census_right[CENSUS_WIDTH-1:0];
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // issue_idx_q is the candidate currently on the hd_* outputs
            if (issue_idx_q == LAST) begin
               state_d = S_DRAIN;
            end else begin
               hd_valid_d  = 1'b1;
               issue_idx_d = issue_idx_q + 1'b1;
               hd_right_d  = right_q[issue_idx_d];
            end
         end
         S_DRAIN: begin
            if (ret_take && ret_cnt_q == LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         issue_idx_q <= '0;
         ret_cnt_q   <= '0;
         best_cost_q <= '0;
         best_disp_q <= '0;
         for (int d = 0; d < MAX_DISP; d++) begin
            right_q[d] <= '0;
         end
         hd_valid_q  <= 1'b0;
         hd_left_q   <= '0;
         hd_right_q  <= '0;
         stray_q     <= 1'b0;
`ifdef DISP_UNIQUENESS_CHECK_EN
         second_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         issue_idx_q <= issue_idx_d;
         ret_cnt_q   <= ret_cnt_d;
         best_cost_q <= best_cost_d;
         best_disp_q <= best_disp_d;
         right_q     <= right_d;
         hd_valid_q  <= hd_valid_d;
         hd_left_q   <= hd_left_d;
         hd_right_q  <= hd_right_d;
         stray_q     <= stray_d;
`ifdef DISP_UNIQUENESS_CHECK_EN
         second_q    <= second_d;
`endif
      end
   end

   // gated with rst so in_ready stays low for the whole reset pulse
   assign in_ready        = (state_q == S_IDLE) && !rst;
   assign hd_valid        = hd_valid_q;
   assign hd_census_left  = hd_left_q;
   assign hd_census_right = hd_right_q;
   assign res_valid       = (state_q == S_DONE);
   assign res_disp        = best_disp_q;
   assign res_cost        = best_cost_q;
   assign stray_err       = stray_q;

`ifdef DISP_UNIQUENESS_CHECK_EN
   // second_best >= best_cost always holds, so the gap never underflows
   assign cost_gap   = second_q - best_cost_q;
   assign res_unique = res_valid && (int'(cost_gap) >= UNIQ_MARGIN);
`else
   assign res_unique = 1'b1;
`endif

endmodule

// File: tb/tb_disparity_search_scheduler.sv
module tb_disparity_search_scheduler;

   localparam int CW = 8;
   localparam int MD = 16;
   localparam int UM = 1;
   localparam int DW = $clog2(CW + 1);
   localparam int PW = $clog2(MD);

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CW-1:0]     in_census_left = '0;
   logic [MD*CW-1:0]  in_census_right = '0;
   logic [CW-1:0]     hd_census_left, hd_census_right;
   logic              hd_valid;
   logic [DW-1:0]     hd_dist;
   logic              hd_dist_valid;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [PW-1:0]     res_disp;
   logic [DW-1:0]     res_cost;
   logic              res_unique;
   logic              stray_err;

   always #5 clk = ~clk;

   disparity_search_scheduler #(.CENSUS_WIDTH(CW), .MAX_DISP(MD), .UNIQ_MARGIN(UM)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_census_left(in_census_left), .in_census_right(in_census_right),
      .hd_census_left(hd_census_left), .hd_census_right(hd_census_right), .hd_valid(hd_valid),
      .hd_dist(hd_dist), .hd_dist_valid(hd_dist_valid),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_disp(res_disp), .res_cost(res_cost), .res_unique(res_unique),
      .stray_err(stray_err)
   );

   // 4-stage Hamming pipeline model; deliberately not reset
   logic [3:0]         pv = '0;
   logic [3:0][DW-1:0] pd = '0;
   always @(posedge clk) begin
      pv <= {pv[2:0], hd_valid};
      pd <= {pd[2:0], DW'($countones(hd_census_left ^ hd_census_right))};
   end
   assign hd_dist       = pd[3];
   assign hd_dist_valid = pv[3];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int hd_cnt = 0, hd_first = -1, hd_last = -1;
   always @(negedge clk) begin
      if (hd_valid) begin
         if (hd_cnt == 0) hd_first = cyc;
         hd_last = cyc;
         hd_cnt++;
      end
   end

   typedef struct {
      logic [PW-1:0] disp;
      logic [DW-1:0] cost;
      logic          uniq;
      int            t;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_fail = 0;

   function automatic exp_t model(input logic [CW-1:0] l, input logic [MD*CW-1:0] r, input int t);
      exp_t e;
      int   c[MD];
      int   bc, bd, sc;
      for (int d = 0; d < MD; d++) c[d] = $countones(l ^ r[d*CW +: CW]);
      bd = 0;
      for (int d = 1; d < MD; d++) if (c[d] < c[bd]) bd = d;
      bc = c[bd];
      sc = (1 << DW) - 1;
      for (int d = 0; d < MD; d++) if (d != bd && c[d] < sc) sc = c[d];
      e.disp = PW'(bd);
      e.cost = DW'(bc);
`ifdef DISP_UNIQUENESS_CHECK_EN
      e.uniq = ((sc - bc) >= UM);
`else
      e.uniq = 1'b1;
`endif
      e.t = t;
      return e;
   endfunction

   // offers a pixel, records the expected result with its accept cycle
   task automatic send(input logic [CW-1:0] l, input logic [MD*CW-1:0] r);
      int n = 0;
      @(negedge clk);
      in_census_left  = l;
      in_census_right = r;
      in_valid        = 1'b1;
      while (!in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      sb.push_back(model(l, r, cyc));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_res(output int t);
      int n = 0;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      t = res_valid ? cyc : -1;
   endtask

   task automatic take_res();
      @(negedge clk) res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   function automatic logic [MD*CW-1:0] fill(input logic [CW-1:0] v);
      logic [MD*CW-1:0] r;
      for (int d = 0; d < MD; d++) r[d*CW +: CW] = v;
      return r;
   endfunction

   function automatic logic [MD*CW-1:0] rand_bus();
      logic [MD*CW-1:0] r;
      for (int d = 0; d < MD; d++) r[d*CW +: CW] = CW'($urandom);
      return r;
   endfunction

   task automatic test_reset();
      logic uniq_rst;
`ifdef DISP_UNIQUENESS_CHECK_EN
      uniq_rst = 1'b0;
`else
      uniq_rst = 1'b1;
`endif
      rst = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_chk++; if ({hd_valid, res_valid, stray_err, hd_census_left, hd_census_right, res_disp, res_cost} !== '0) begin
         n_fail++; $display("FAIL rst_outputs: hd_valid=%b res_valid=%b stray=%b hl=%h hr=%h disp=%0d cost=%0d want all 0",
                            hd_valid, res_valid, stray_err, hd_census_left, hd_census_right, res_disp, res_cost); end
      n_chk++; if (res_unique !== uniq_rst) begin n_fail++; $display("FAIL rst_unique: got %b want %b", res_unique, uniq_rst); end
      @(negedge clk) rst = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_all_equal();
      int   t;
      exp_t e;
      hd_cnt = 0;
      send(8'hA5, fill(8'hA5));
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (t !== e.t + 21) begin n_fail++; $display("FAIL eq_latency: got cycle %0d want %0d", t, e.t + 21); end
      n_chk++; if (res_disp !== 0 || res_cost !== 0) begin n_fail++; $display("FAIL eq_result: got disp %0d cost %0d want 0 0", res_disp, res_cost); end
      n_chk++; if (res_disp !== e.disp || res_cost !== e.cost) begin n_fail++; $display("FAIL eq_model: got disp %0d cost %0d want %0d %0d", res_disp, res_cost, e.disp, e.cost); end
      n_chk++; if (hd_cnt !== 16) begin n_fail++; $display("FAIL eq_hd_count: got %0d want 16", hd_cnt); end
      n_chk++; if (hd_first !== e.t + 1 || hd_last !== e.t + 16) begin
         n_fail++; $display("FAIL eq_hd_window: got %0d..%0d want %0d..%0d", hd_first, hd_last, e.t + 1, e.t + 16); end
      n_chk++; if (stray_err !== 1'b0) begin n_fail++; $display("FAIL eq_stray: got %b want 0", stray_err); end
      take_res();
   endtask

   task automatic test_single_min();
      int               t;
      exp_t             e;
      logic [MD*CW-1:0] r;
      r = fill(8'hFF);
      r[5*CW +: CW] = 8'h01;
      send(8'h00, r);
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (t !== e.t + 21) begin n_fail++; $display("FAIL min5_latency: got cycle %0d want %0d", t, e.t + 21); end
      n_chk++; if (res_disp !== 5 || res_cost !== 1) begin n_fail++; $display("FAIL min5_result: got disp %0d cost %0d want 5 1", res_disp, res_cost); end
      n_chk++; if (res_unique !== e.uniq) begin n_fail++; $display("FAIL min5_unique: got %b want %b", res_unique, e.uniq); end
      take_res();
   endtask

   task automatic test_tie_unique();
      int               t;
      exp_t             e;
      logic [MD*CW-1:0] r;
      r = fill(8'h0F);
      r[3*CW +: CW] = 8'h01;
      r[9*CW +: CW] = 8'h01;
      send(8'h00, r);
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (res_disp !== 3 || res_cost !== 1) begin n_fail++; $display("FAIL tie_result: got disp %0d cost %0d want 3 1", res_disp, res_cost); end
      n_chk++; if (res_unique !== e.uniq) begin n_fail++; $display("FAIL tie_unique: got %b want %b", res_unique, e.uniq); end
      take_res();
      r[9*CW +: CW] = 8'h03;
      send(8'h00, r);
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (res_disp !== 3 || res_cost !== 1) begin n_fail++; $display("FAIL gap_result: got disp %0d cost %0d want 3 1", res_disp, res_cost); end
      n_chk++; if (res_unique !== 1'b1) begin n_fail++; $display("FAIL gap_unique: got %b want 1", res_unique); end
      take_res();
   endtask

   task automatic test_random();
      int   t;
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         send(CW'($urandom), rand_bus());
         wait_res(t);
         e = sb.pop_front();
         n_chk++; if (t < 0 || res_disp !== e.disp || res_cost !== e.cost || res_unique !== e.uniq) begin
            n_fail++; $display("FAIL rand_%0d: got t=%0d disp %0d cost %0d uniq %b want disp %0d cost %0d uniq %b",
                               k, t, res_disp, res_cost, res_unique, e.disp, e.cost, e.uniq); end
         take_res();
      end
   endtask

   task automatic test_back_to_back();
      int            t, bad;
      exp_t          e;
      logic [PW-1:0] d0;
      logic [DW-1:0] c0;
      send(8'h5A, rand_bus());
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (res_disp !== e.disp || res_cost !== e.cost) begin n_fail++; $display("FAIL hold_result: got disp %0d cost %0d want %0d %0d", res_disp, res_cost, e.disp, e.cost); end
      d0 = res_disp;
      c0 = res_cost;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!res_valid || res_disp !== d0 || res_cost !== c0 || in_ready || hd_valid) bad++;
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
      take_res();
      n_chk++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL release_idle: got res_valid %b in_ready %b want 0 1", res_valid, in_ready); end
      hd_cnt = 0;
      send(8'hC3, rand_bus());
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (t !== e.t + 21 || res_disp !== e.disp || res_cost !== e.cost) begin
         n_fail++; $display("FAIL b2b_result: got t=%0d disp %0d cost %0d want t=%0d disp %0d cost %0d", t, res_disp, res_cost, e.t + 21, e.disp, e.cost); end
      take_res();
   endtask

   task automatic test_reset_mid();
      int   t, n;
      exp_t e;
      hd_cnt = 0;
      send(8'h3C, rand_bus());
      n = 0;
      while (hd_cnt < 6 && n < 50) begin
         @(negedge clk);
         #1 n++;
      end
      rst = 1'b1;
      #1;
      void'(sb.pop_back());
      n_chk++; if ({in_ready, hd_valid, res_valid, hd_census_left, hd_census_right, res_disp, res_cost} !== '0) begin
         n_fail++; $display("FAIL midrst_outputs: ready=%b hd_valid=%b res_valid=%b hl=%h hr=%h disp=%0d cost=%0d want all 0",
                            in_ready, hd_valid, res_valid, hd_census_left, hd_census_right, res_disp, res_cost); end
      @(negedge clk) rst = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got in_ready %b want 1", in_ready); end
      repeat (10) @(negedge clk);
      n_chk++; if (stray_err !== 1'b1) begin n_fail++; $display("FAIL midrst_stray: got %b want 1", stray_err); end
      send(8'h81, rand_bus());
      wait_res(t);
      e = sb.pop_front();
      n_chk++; if (t !== e.t + 21 || res_disp !== e.disp || res_cost !== e.cost || res_unique !== e.uniq) begin
         n_fail++; $display("FAIL midrst_next: got t=%0d disp %0d cost %0d uniq %b want t=%0d disp %0d cost %0d uniq %b",
                            t, res_disp, res_cost, res_unique, e.t + 21, e.disp, e.cost, e.uniq); end
      take_res();
   endtask

   initial begin
      test_reset();
      test_all_equal();
      test_single_min();
      test_tie_unique();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
